pkt_mem_reader: RTL

- Read side of the packet data memory: takes a packet descriptor (start/end address) once processing of a stored packet is done.
- Fetches the packet words from the memory's read port (synchronous, 1-cycle latency).
- Emits them onto the standard pipeline output bus (out_data/out_ctrl/out_wr/out_rdy) and acknowledges completion so the write-side controller can free the buffer space.
- Sits between the packet data memory / processor and the next pipeline stage.

---
 rtl/pkt_mem_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pkt_mem_reader.sv
// Read side of the packet data memory: fetches one packet's words from a
// 1-cycle-latency read port and streams them onto the pipeline output bus.
//
// state | meaning
// IDLE  | waiting for a packet descriptor
// READ  | issuing memory reads while buffer space allows
// DRAIN | all reads issued, emptying the output buffer
// ACK   | one-cycle pkt_ack pulse, packet counter bump
module pkt_mem_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pkt_valid,
  input  logic [ADDR_WIDTH-1:0]            pkt_start_addr,
  input  logic [ADDR_WIDTH-1:0]            pkt_end_addr,
  output logic                             pkt_ack,
  output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
  output logic                             mem_rd_en,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic                             busy,
  output logic [31:0]                      pkt_count
);

  localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_ACK
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH-1:0] addr_diff;
  logic                  inflight;
  logic [WORD_W-1:0]     buf_mem [2];
  logic                  buf_wr_sel;
  logic                  buf_rd_sel;
  logic [1:0]            buf_count;
  logic [2:0]            occupancy;
  logic                  issue;

  assign addr_diff = pkt_end_addr - pkt_start_addr;
  assign out_wr    = (buf_count != 2'd0) && out_rdy;

  // Words held plus owed after this cycle's pop; a new read is allowed only
  // if it still fits in the two buffer entries, so a stalled sink never overflows.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, out_wr};
  assign issue     = (state == S_READ) && (remaining != '0) && (occupancy < 3'd2);

  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_ptr;
  assign {out_ctrl, out_data} = buf_mem[buf_rd_sel];
  assign pkt_ack     = (state == S_ACK);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      remaining <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pkt_valid) begin
            rd_ptr    <= pkt_start_addr;
            remaining <= {1'b0, addr_diff} + REM_ONE;
            state     <= S_READ;
          end
        end
        S_READ: begin
          if (issue) begin
            rd_ptr    <= rd_ptr + ADDR_ONE;
            remaining <= remaining - REM_ONE;
          end
          if (remaining == '0) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Look ahead at this cycle's pop so the ack follows the last word directly.
          if (!inflight && ((buf_count == 2'd0) || ((buf_count == 2'd1) && out_wr))) begin
            state <= S_ACK;
          end
        end
        S_ACK: begin
          pkt_count <= pkt_count + 32'd1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight   <= 1'b0;
      buf_wr_sel <= 1'b0;
      buf_rd_sel <= 1'b0;
      buf_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      inflight <= issue;
      if (inflight) begin
        buf_mem[buf_wr_sel] <= mem_rd_data;
        buf_wr_sel          <= ~buf_wr_sel;
      end
      if (out_wr) begin
        buf_rd_sel <= ~buf_rd_sel;
      end
      buf_count <= buf_count + {1'b0, inflight} - {1'b0, out_wr};
    end
  end

endmodule
